// File: rtl/four_nor_pkg.sv
// Shared types and helpers for the four-input NOR stimulus sequencer.
package four_nor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of distinct {a,b,c,d} combinations walked per sequence.
   localparam int NUM_VEC = 16;

   // Index of the final vector, where a run either wraps or completes.
   localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

   // Reflected Gray code of a 4-bit index.
   function automatic logic [3:0] bin2gray(input logic [3:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/four_nor_vecgen_hold_timer.sv
// Hold counter for the vector sequencer: counts 0..HOLD-1 while enabled and
// flags the final cycle of each hold period with a terminal-count strobe.
module hold_timer
   import four_nor_pkg::*;
#(
   parameter int HOLD = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   // A single-cycle hold still needs a one-bit counter.
   localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [W-1:0] TC_VAL = W'(HOLD - 1);

   logic [W-1:0] cnt_q;

   // Terminal count is only meaningful while the counter is running.
   assign tc = en && (cnt_q == TC_VAL);

   // Count up while enabled, restarting from zero after the terminal cycle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tc ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/four_nor_vecgen.sv
// Clocked stimulus sequencer for the four-input NOR stage: walks all 16
// {a,b,c,d} combinations, each held HOLD cycles, with restart/abort and an
// optional continuous wrap. Every output is registered.
module four_nor_vecgen
   import four_nor_pkg::*;
#(
   parameter int HOLD = 50,
   parameter int GRAY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       cont,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       vld,
   output logic [3:0] vec_idx,
   output logic       busy,
   output logic       done
);

   state_t     state_q;
   logic [3:0] idx_q;
   logic [3:0] idx_d;
   logic [3:0] vec_q;
   logic       vld_q;
   logic       busy_q;
   logic       done_q;
   logic       tc;
   logic       tmr_en;
   logic       tmr_clr;

   // Map a sequence index to the driven vector according to the chosen order.
   function automatic logic [3:0] code_vec(input logic [3:0] idx);
      return (GRAY != 0) ? bin2gray(idx) : idx;
   endfunction

   assign idx_d   = idx_q + 4'd1;
   // Outside RUN the timer is held at zero so a new run always starts fresh.
   assign tmr_en  = (state_q == RUN);
   assign tmr_clr = (state_q != RUN);

   hold_timer #(
      .HOLD (HOLD)
   ) u_hold_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .en  (tmr_en),
      .tc  (tc)
   );

   // Sequencer FSM with registered vector, index and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               idx_q  <= '0;
               if (start && !stop) begin
                  state_q <= RUN;
                  vec_q   <= code_vec(4'd0);
                  vld_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  vec_q   <= '0;
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            RUN: begin
               // Abort wins over any step or wrap due this cycle.
               if (stop) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
                  vec_q   <= '0;
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (tc) begin
                  if (idx_q != LAST_IDX) begin
                     idx_q <= idx_d;
                     vec_q <= code_vec(idx_d);
                     vld_q <= 1'b1;
                  end else if (cont) begin
                     idx_q <= '0;
                     vec_q <= code_vec(4'd0);
                     vld_q <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     idx_q   <= '0;
                     vec_q   <= '0;
                     vld_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  vld_q <= 1'b0;
               end
            end
            DONE: begin
               // Single completion cycle; a start seen here is dropped.
               state_q <= IDLE;
               idx_q   <= '0;
               vec_q   <= '0;
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
               vec_q   <= '0;
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign {a, b, c, d} = vec_q;
   assign vld          = vld_q;
   assign vec_idx      = idx_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_four_nor_vecgen.sv
// Bench for four_nor_vecgen: several parameterisations share one stimulus
// stream and are compared every cycle against a run-time-based model.
module tb_four_nor_vecgen;

   localparam int NI = 4;
   localparam int HOLDS [NI] = '{4, 1, 2, 50};
   localparam int GRAYS [NI] = '{0, 1, 0, 0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic cont = 1'b0;

   logic       a_w    [NI];
   logic       b_w    [NI];
   logic       c_w    [NI];
   logic       d_w    [NI];
   logic       vld_w  [NI];
   logic [3:0] idx_w  [NI];
   logic       busy_w [NI];
   logic       done_w [NI];

   int checks = 0;
   int errors = 0;

   // Reference model: whether a run is active, how many cycles it has been
   // running, and whether the completion cycle is pending.
   bit m_run [NI];
   bit m_dn  [NI];
   int m_t   [NI];

   // Run statistics for instance 0 and Gray adjacency tracking for instance 1.
   bit   cnt_en = 1'b0;
   int   nvld = 0;
   int   nbusy = 0;
   int   ndone = 0;
   logic prev_busy1 = 1'b0;
   logic [3:0] prev_vec1 = '0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      four_nor_vecgen #(
         .HOLD (HOLDS[g]),
         .GRAY (GRAYS[g])
      ) dut (
         .clk     (clk),
         .rst     (rst),
         .start   (start),
         .stop    (stop),
         .cont    (cont),
         .a       (a_w[g]),
         .b       (b_w[g]),
         .c       (c_w[g]),
         .d       (d_w[g]),
         .vld     (vld_w[g]),
         .vec_idx (idx_w[g]),
         .busy    (busy_w[g]),
         .done    (done_w[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model of instance g by one clock edge using current inputs.
   task automatic model_step(input int g);
      int h;
      h = HOLDS[g];
      if (rst) begin
         m_run[g] = 1'b0;
         m_dn[g]  = 1'b0;
         m_t[g]   = 0;
      end else if (m_dn[g]) begin
         m_dn[g] = 1'b0;
      end else if (!m_run[g]) begin
         if (start && !stop) begin
            m_run[g] = 1'b1;
            m_t[g]   = 0;
         end
      end else if (stop) begin
         m_run[g] = 1'b0;
      end else begin
         m_t[g]++;
         if (m_t[g] == 16 * h) begin
            if (cont) begin
               m_t[g] = 0;
            end else begin
               m_run[g] = 1'b0;
               m_dn[g]  = 1'b1;
            end
         end
      end
   endtask

   // Expected {vec, vld, vec_idx, busy, done} for instance g.
   function automatic logic [10:0] exp_of(input int g);
      int h;
      int ix;
      logic [3:0] v;
      logic vl;
      h  = HOLDS[g];
      ix = m_run[g] ? (m_t[g] / h) : 0;
      v  = m_run[g] ? 4'((GRAYS[g] != 0) ? (ix ^ (ix >> 1)) : ix) : 4'd0;
      vl = m_run[g] && ((m_t[g] % h) == 0);
      return {v, vl, 4'(ix), m_run[g], m_dn[g]};
   endfunction

   function automatic logic [10:0] got_of(input int g);
      return {a_w[g], b_w[g], c_w[g], d_w[g], vld_w[g], idx_w[g], busy_w[g], done_w[g]};
   endfunction

   // One clock: update the model on the edge, compare on the falling edge.
   task automatic cyc();
      logic [3:0] v1;
      @(posedge clk);
      for (int g = 0; g < NI; g++) model_step(g);
      @(negedge clk);
      for (int g = 0; g < NI; g++)
         check_eq($sformatf("outs_inst%0d", g), 32'(got_of(g)), 32'(exp_of(g)));
      v1 = {a_w[1], b_w[1], c_w[1], d_w[1]};
      if (prev_busy1 && busy_w[1] && vld_w[1])
         check_eq("gray_one_bit", 32'($countones(v1 ^ prev_vec1)), 32'd1);
      prev_busy1 = busy_w[1];
      prev_vec1  = v1;
      if (cnt_en) begin
         nvld  += int'(vld_w[0]);
         nbusy += int'(busy_w[0]);
         ndone += int'(done_w[0]);
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      // Reset held for three cycles, then idle.
      rst = 1'b1;
      run_cycles(3);
      rst = 1'b0;
      run_cycles(5);

      // Binary / Gray / long runs started together, non-continuous.
      cont   = 1'b0;
      start  = 1'b1;
      cnt_en = 1'b1;
      cyc();
      start = 1'b0;
      run_cycles(79);
      cnt_en = 1'b0;
      check_eq("bin_vld_pulses", 32'(nvld), 32'd16);
      check_eq("bin_busy_cycles", 32'(nbusy), 32'd64);
      check_eq("bin_done_pulses", 32'(ndone), 32'd1);

      // Continuous wrap, then clear cont mid-run.
      rst = 1'b1;
      cyc();
      rst  = 1'b0;
      cont = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_cycles(45);
      cont = 1'b0;
      run_cycles(45);

      // Abort in the middle of index 7 for the HOLD=4 instance.
      rst = 1'b1;
      cyc();
      rst   = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_cycles(29);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      run_cycles(3);
      // start and stop together in IDLE.
      rst = 1'b1;
      cyc();
      rst   = 1'b0;
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      run_cycles(3);
      check_eq("start_stop_idle", 32'(busy_w[0]), 32'd0);

      // Ignored start at index 5, reset at index 9, then restart.
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_cycles(20);
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_cycles(15);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_eq("rst_mid_busy", 32'(busy_w[0]), 32'd0);
      run_cycles(2);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check_eq("restart_idx", 32'(idx_w[0]), 32'd0);
      check_eq("restart_vld", 32'(vld_w[0]), 32'd1);
      run_cycles(10);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         stop  = ($urandom_range(0, 79) == 0);
         start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 39) == 0) cont = ~cont;
         cyc();
      end
      rst   = 1'b0;
      stop  = 1'b0;
      start = 1'b0;
      run_cycles(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/four_nor_vecgen.md
# four_nor_vecgen

Stimulus sequencer that sits directly upstream of the four-input NOR stage and drives its `a`, `b`, `c`, `d` inputs. On a start request it steps through all 16 input combinations, holding each for a programmable number of clock cycles. It then signals completion, or wraps around and repeats when continuous mode is set. This replaces free-running delay-based toggling with a clocked, restartable, abortable sequence that checkers downstream of the NOR stage can align to.

## Interface
Parameters:
- `HOLD`, default 50: clock cycles each vector is held. Legal range is 1 or more.
- `GRAY`, default 0: vector order. 0 = binary count, 1 = reflected Gray code.

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — level-sampled request to begin a sequence. Honoured only in IDLE.
- `stop`  in  1  — abort request. Honoured in RUN; overrides `start` in every state.
- `cont`  in  1  — continuous mode, sampled at each wrap point.
- `a`, `b`, `c`, `d`  out  1 each  — NOR-stage input vector. `a` is the MSB and `d` the LSB of the coded index.
- `vld`  out  1  — one-cycle pulse in the first cycle a new vector is driven.
- `vec_idx`  out  4  — sequence index (0–15) of the vector currently driven.
- `busy`  out  1  — high while in RUN.
- `done`  out  1  — one-cycle pulse when a non-continuous sequence completes.

## Operation
- FSM states are IDLE, RUN and DONE. A hold counter runs from 0 to HOLD-1, and a 4-bit index counter runs from 0 to 15.
- Reset puts the FSM in IDLE and clears every output and counter to 0: `a`, `b`, `c`, `d`, `vld`, `vec_idx`, `busy` and `done` are all 0.
- IDLE:
  - If `start`=1 and `stop`=0, go to RUN. Index is 0, hold counter is 0, `vld`=1.
  - Otherwise stay in IDLE.
- RUN:
  - Hold counter increments every cycle.
  - When the hold counter reaches HOLD-1, it returns to 0.
    - If index < 15: index increments and `vld` pulses.
    - If index = 15 and `cont`=1: index wraps to 0, `vld` pulses, and `done` stays 0.
    - If index = 15 and `cont`=0: go to DONE.
- DONE lasts one cycle: `done`=1, `busy`=0 and vector outputs are 0. It then returns to IDLE unconditionally, and `start` is ignored during DONE.
- `stop`=1 in RUN aborts:
  - Next cycle the FSM is in IDLE with all outputs 0.
  - No `done` pulse is produced.
  - `stop` takes priority over a coincident step or wrap.
- `start` while in RUN or DONE is ignored; it is not queued.
- Vector coding:
  - GRAY=0: `{a,b,c,d}` = index.
  - GRAY=1: `{a,b,c,d}` = index ^ (index >> 1).
- Vector outputs, `vec_idx`, `vld`, `busy` and `done` are all registered, with no combinational path from any input.
- Outside RUN, vector outputs are forced to 0.
- The hold counter width is max(1, clog2(HOLD)). With HOLD=1 the vector changes every cycle and `vld` is high continuously throughout RUN.

## Timing
- Start latency: `start` sampled at edge N gives `busy`=1, `vld`=1 and vector 0 valid after edge N.
- Each vector is stable for exactly HOLD cycles.
- A full non-continuous run lasts 16·HOLD cycles of `busy`, followed by 1 cycle of `done`.
- Back-to-back runs: the earliest re-start is `start` sampled in the cycle after DONE. The minimum gap between runs is therefore 1 IDLE cycle.
- Reset mid-run: `rst` sampled at edge N gives IDLE with all outputs 0 after edge N. `rst` has priority over `start` and `stop`.
- In continuous mode, a `cont` change takes effect only at the next wrap point (index 15, final hold cycle).

## Structure
- Shared package `four_nor_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - the constant `NUM_VEC` = 16;
  - a `bin2gray` function on 4-bit values.
- The hold counter with its terminal-count strobe is split into one sub-module, `hold_timer`, parameterised by HOLD. It has ports `clk`, `rst`, `clr`, `en` and `tc`.
- Everything else stays in `four_nor_vecgen`.

## Test plan
- **Reset:** HOLD=50, assert `rst` for 3 cycles, then idle → all outputs 0, `busy`=0, no `vld` or `done`.
- **Binary run:** HOLD=4, GRAY=0, `cont`=0, pulse `start` → 16 `vld` pulses 4 cycles apart, `{a,b,c,d}` goes 0000, 0001 … 1111. `busy` is high for 64 cycles, then a single `done` pulse, then outputs are 0.
- **Gray run:** GRAY=1, HOLD=1 → the vector sequence is 0000, 0001, 0011, 0010 … 1000, with exactly one bit changing per cycle, `vld` high for 16 cycles, then `done`.
- **Continuous wrap:** `cont`=1, HOLD=2 → after index 15, `vec_idx` returns to 0 with `vld`=1 and `done`=0. Clearing `cont` mid-run ends the sequence at the next index-15 completion.
- **Abort:** assert `stop` when index=7 in the middle of its hold → next cycle IDLE, outputs 0, no `done`. `start` and `stop` asserted together in IDLE → the block stays in IDLE.
- **Ignored start / reset mid-run:** pulse `start` at index 5 → the sequence is unaffected. Assert `rst` at index 9 → outputs are 0 on the next cycle, and a later `start` restarts from index 0.
